// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundle of the PC-generator, memory and decode handshakes of the fetch unit.
// master: the fetch unit (drives pc_take, mem_req_*, ins_valid/data/addr).
// slave : the surrounding PC generator, memory and decode stage.
interface pc_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_take;
  logic              flush;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              ins_valid;
  logic              ins_ready;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_addr;
  modport master (
    input  pc_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, ins_ready,
    output pc_take, mem_req_valid, mem_req_addr, ins_valid, ins_data, ins_addr
  );
  modport slave (
    output pc_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data, ins_ready,
    input  pc_take, mem_req_valid, mem_req_addr, ins_valid, ins_data, ins_addr
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch unit; issues PC addresses to memory, queues in-order responses for decode.
// Ports: clock, reset_n (async active-low); bus (pc_fetch_if.master): pc_addr/pc_take from the PC
// generator, flush redirect, mem_req_valid/ready/addr and mem_rsp_valid/data to memory,
// ins_valid/ready/data/addr to decode.
// Option: define PC_FETCH_BYPASS_EN to forward a response straight to decode when it lands in the head slot.
module pc_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic      clock,
  input logic      reset_n,
  pc_fetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W1 = CW + 1;
  logic [PW-1:0]     alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0]     used_q, used_d, drop_q, drop_d, pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  full_q, full_d;
  logic [W1-1:0]     occ, drop_sum;
  logic              take, rsp_drop, rsp_fill, pop, byp;
  assign occ           = {1'b0, used_q} + {1'b0, drop_q};
  assign bus.mem_req_valid = (occ < W1'(DEPTH)) && !bus.flush;
  assign bus.mem_req_addr  = bus.pc_addr;
  assign take          = bus.mem_req_valid && bus.mem_req_ready;
  assign bus.pc_take   = take;
  // pend_q counts live in-flight requests; drop_q counts stale ones killed by a flush.
  // A response with neither outstanding is ignored.
  assign rsp_drop      = bus.mem_rsp_valid && drop_q != '0;
  assign rsp_fill      = bus.mem_rsp_valid && drop_q == '0 && pend_q != '0;
`ifdef PC_FETCH_BYPASS_EN
  assign byp           = bus.mem_rsp_valid && used_q == CW'(1) && drop_q == '0 && head_q == fill_q;
`else
  assign byp           = 1'b0;
`endif
  assign bus.ins_valid = (full_q[head_q] && used_q != '0) || byp;
  assign bus.ins_data  = byp ? bus.mem_rsp_data : data_q[head_q];
  assign bus.ins_addr  = addr_q[head_q];
  assign pop           = bus.ins_valid && bus.ins_ready && !bus.flush;
  assign drop_sum      = {1'b0, drop_q} + {1'b0, pend_q} - W1'(rsp_drop | rsp_fill);
  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    used_d  = used_q;
    drop_d  = drop_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    data_d  = data_q;
    full_d  = full_q;
    if (bus.flush) begin
      // every live in-flight request becomes stale; the response arriving now is discarded too
      drop_d = drop_sum[CW-1:0];
      pend_d = '0;
      used_d = '0;
      full_d = '0;
      fill_d = alloc_q;
      head_d = alloc_q;
    end else begin
      if (take) begin
        addr_d[alloc_q] = bus.pc_addr;
        full_d[alloc_q] = 1'b0;
        alloc_d         = alloc_q + PW'(1);
      end
      if (rsp_drop) drop_d = drop_q - CW'(1);
      if (pop) begin
        full_d[head_q] = 1'b0;
        head_d         = head_q + PW'(1);
      end
      if (rsp_fill) begin
        fill_d = fill_q + PW'(1);
        // a bypassed word consumed this cycle never needs to be stored
        if (!(byp && pop)) begin
          data_d[fill_q] = bus.mem_rsp_data;
          full_d[fill_q] = 1'b1;
        end
      end
      used_d = used_q + CW'(take) - CW'(pop);
      pend_d = pend_q + CW'(take) - CW'(rsp_fill);
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      used_q  <= '0;
      drop_q  <= '0;
      pend_q  <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      full_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
      used_q  <= used_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      full_q  <= full_d;
    end
endmodule
